simon_pipe_ctrl: RTL
====================

Name: simon_pipe_ctrl

Overview:
Sequencing controller for the 32-round Simon32/64 encryption pipeline and its key schedule. It owns the plaintext-accept and key-load handshakes, and tracks a valid/tag token alongside each block in the pipeline so that ciphertext emerges with a qualifying strobe. A key change is allowed only once the pipeline has drained and the new round keys have had time to settle. The block sits between the host interface and the pipeline/key-schedule pair and drives their plaintext-capture enable and keytext.

Parameters:
LATENCY, 33, number of clock edges from the plaintext-capture edge to the ciphertext-register edge, inclusive (32 round registers plus 1 output register).
KEY_LAT, 32, number of cycles after key_load before all round keys are stable.
TAG_W, 4, width of the user tag carried with each block.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  plaintext request
in_ready  out  1  plaintext accepted when in_valid && in_ready at a clk edge
in_tag  in  TAG_W  tag carried with the accepted block
pt_capture  out  1  combinational, equal to in_valid && in_ready; enables the pipeline's plaintext register
key_valid  in  1  new-key request
key_ready  out  1  key accepted when key_valid && key_ready at a clk edge
key_in  in  64  new keytext
pipe_key  out  64  registered keytext driven to the key schedule
key_load  out  1  one-cycle pulse after a key is accepted
out_valid  out  1  ciphertext register holds a valid block this cycle
out_tag  out  TAG_W  tag of that block
inflight  out  6  number of accepted blocks not yet presented at the output
busy  out  1  high when state != RUN or inflight != 0

Behaviour:
- Reset values (register outputs, set on the first clk edge with rst=1):
  - state = KEY_WAIT, pipe_key = 0, key_load = 0.
  - out_valid = 0, out_tag = 0, inflight = 0.
  - Valid/tag shift register cleared; settle counter = 0.
- Combinational outputs while rst=1 (derived from the reset state):
  - in_ready = 0, pt_capture = 0.
  - key_ready = 1, busy = 1.
- Reset asserted mid-operation discards all in-flight tokens. Their data still flows through the datapath, but out_valid never rises for it.
- States:
  - KEY_WAIT: no valid key loaded.
  - SETTLE: counting KEY_LAT.
  - RUN: normal operation.
  - DRAIN: key pending, waiting for the pipeline to empty.
- Transitions:
  - KEY_WAIT -> SETTLE on key accept.
  - SETTLE -> RUN when the counter reaches KEY_LAT-1.
  - RUN -> DRAIN when key_valid=1 and inflight != 0.
  - RUN -> SETTLE on key accept with inflight=0.
  - DRAIN -> SETTLE on key accept.
- Handshake rules:
  - in_ready = (state==RUN) && !key_valid. A pending key always wins over a simultaneous plaintext request.
  - key_ready = (state==KEY_WAIT) || ((state==RUN || state==DRAIN) && inflight==0). key_ready is 0 in SETTLE.
  - A key_valid arriving during SETTLE waits until RUN, then is accepted immediately if inflight==0.
- Key accept: pipe_key <= key_in and key_load <= 1 on the accept edge, so key_load is high the following cycle only. The settle counter restarts from 0 on that edge.
- Token pipeline:
  - The shift register is LATENCY-1 stages of {valid, tag}.
  - Stage 0 loads {pt_capture, in_tag} each edge; each other stage loads the previous one.
  - out_valid/out_tag are registered from the last stage.
  - A block accepted at edge t gives out_valid=1 between edges t+LATENCY-1 and t+LATENCY, for exactly 1 cycle per block.
  - Back-to-back accepts give back-to-back out_valid with no gaps. There is no output backpressure.
- inflight:
  - Increments on accept and decrements when out_valid is registered high (edge t+LATENCY-1).
  - Simultaneous increment and decrement leaves it unchanged.
  - Maximum value is LATENCY-1 = 32 with continuous input; it cannot overflow its 6 bits.
- busy is combinational.

Test Plan:
1. Reset then key load: rst 1 for 2 cycles; key_in=0x1918111009080100 at cycle 3 -> key_load pulses 1 cycle, pipe_key matches key_in, in_ready stays 0 for exactly 32 cycles (KEY_LAT), then rises.
2. Single block: in_valid 1 cycle, in_tag=0x5, accepted at edge t -> out_valid high only between edges t+32 and t+33 with out_tag=0x5; inflight goes 1 then 0. Integrated with the pipeline, plaintext 0x65656877 under the key from test 1 yields ciphertext 0xc69be9bb.
3. Streaming: 40 consecutive accepts, tags 0..15 wrapping -> 40 consecutive out_valid cycles in the same order; inflight saturates at 32.
4. Key change under load: key_valid asserted while inflight=10 -> in_ready drops the same cycle, state DRAIN, key_ready rises only when inflight=0, then 32-cycle settle before in_ready returns.
5. Simultaneous in_valid and key_valid in RUN with inflight=0 -> key accepted, pt_capture=0, no token inserted.
6. Reset mid-stream with inflight=20 -> out_valid never rises for those blocks; inflight=0 and state KEY_WAIT after the reset edge.

Source files
------------

// File: rtl/simon_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// simon_pipe_ctrl
//
// Sequencing controller for the 32-round Simon32/64 encryption pipeline and its
// key schedule. It accepts plaintext and key requests from the host, drives the
// pipeline's plaintext-capture enable and the key schedule's keytext, and
// carries a {valid, tag} token alongside every block so that ciphertext leaves
// with a qualifying strobe. A new key is only taken once the pipeline is empty,
// and plaintext is held off until the round keys derived from it have settled.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   in_valid    plaintext request
//   in_ready    plaintext accepted when in_valid && in_ready at a clk edge
//   in_tag      user tag travelling with the accepted block
//   pt_capture  combinational in_valid && in_ready, enables the plaintext register
//   key_valid   new-key request
//   key_ready   key accepted when key_valid && key_ready at a clk edge
//   key_in      new keytext
//   pipe_key    registered keytext driven to the key schedule
//   key_load    one-cycle pulse following a key accept
//   out_valid   ciphertext register holds a valid block this cycle
//   out_tag     tag of that block
//   inflight    accepted blocks not yet presented at the output
//   busy        high unless in RUN with an empty pipeline
// -----------------------------------------------------------------------------
module simon_pipe_ctrl #(
  parameter int LATENCY = 33,
  parameter int KEY_LAT = 32,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic             pt_capture,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [63:0]      key_in,
  output logic [63:0]      pipe_key,
  output logic             key_load,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [5:0]       inflight,
  output logic             busy
);

  // Token stages ahead of the output register.
  localparam int STAGES = LATENCY - 1;
  localparam int CNT_W  = $clog2(KEY_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_LAT - 1);

  typedef enum logic [1:0] {
    KEY_WAIT = 2'd0,
    SETTLE   = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             key_acc;

  logic             tok_vld_p [STAGES];
  logic [TAG_W-1:0] tok_tag_p [STAGES];

  // Occupancy update; an accept and a retire on the same edge cancel out.
  function automatic logic [5:0] inflight_step(input logic [5:0] cur,
                                               input logic       inc,
                                               input logic       dec);
    logic [5:0] res;
    res = cur;
    case ({inc, dec})
      2'b10:   res = cur + 6'd1;
      2'b01:   res = cur - 6'd1;
      default: res = cur;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM: handshakes and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    key_ready = 1'b0;
    key_acc   = 1'b0;

    // A pending key always blocks new plaintext so the pipeline can drain.
    in_ready  = (state == RUN) && !key_valid;
    key_ready = (state == KEY_WAIT) ||
                (((state == RUN) || (state == DRAIN)) && (inflight == 6'd0));
    key_acc   = key_valid && key_ready;

    case (state)
      KEY_WAIT: if (key_acc) state_nxt = SETTLE;
      SETTLE:   if (settle_cnt == CNT_LAST) state_nxt = RUN;
      RUN: begin
        if (key_acc)                               state_nxt = SETTLE;
        else if (key_valid && (inflight != 6'd0))  state_nxt = DRAIN;
      end
      DRAIN:    if (key_acc) state_nxt = SETTLE;
      default:  state_nxt = KEY_WAIT;
    endcase
  end

  assign pt_capture = in_valid && in_ready;
  assign busy       = (state != RUN) || (inflight != 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= KEY_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Settle counter restarts on every key accept and parks at its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (key_acc) begin
      settle_cnt <= '0;
    end else if ((state == SETTLE) && (settle_cnt != CNT_LAST)) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Key register feeding the key schedule
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_key <= 64'd0;
      key_load <= 1'b0;
    end else begin
      key_load <= key_acc;
      if (key_acc) begin
        pipe_key <= key_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Token stage 0: captured alongside the plaintext register
  // Token stages 1..STAGES-1: follow the round registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        tok_vld_p[i] <= 1'b0;
        tok_tag_p[i] <= '0;
      end
    end else begin
      tok_vld_p[0] <= pt_capture;
      tok_tag_p[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) begin
        tok_vld_p[i] <= tok_vld_p[i-1];
        tok_tag_p[i] <= tok_tag_p[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: aligned with the ciphertext register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
    end else begin
      out_valid <= tok_vld_p[STAGES-1];
      out_tag   <= tok_tag_p[STAGES-1];
    end
  end

  // A block retires on the same edge its out_valid is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 6'd0;
    end else begin
      inflight <= inflight_step(inflight, pt_capture, tok_vld_p[STAGES-1]);
    end
  end

endmodule
